// File: rtl/cpu_defs.sv
// Definitions shared by the fetch stage and the hazard unit: the reset PC, the
// NOP encoding, and the redirect-select codes with their priority rule.
package cpu_defs;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;  // sll $0,$0,0
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'd0,
        SEL_JUMP   = 2'd1,
        SEL_BRANCH = 2'd2,
        SEL_JR     = 2'd3
    } redirect_sel_e;

    // jr beats a taken branch, which beats j/jal.
    function automatic redirect_sel_e redirect_select(input logic jr,
                                                      input logic branch_taken,
                                                      input logic jump);
        redirect_sel_e sel;
        sel = SEL_SEQ;
        if (jr)                sel = SEL_JR;
        else if (branch_taken) sel = SEL_BRANCH;
        else if (jump)         sel = SEL_JUMP;
        return sel;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds on stall, loads a bubble on flush, otherwise
// captures the fetched word and its PC+4 as a valid instruction.
module if_id_reg #(
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        write_en_i,
    input  logic        flush_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_plus4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q, valid_d;

    // Stall takes precedence over flush so a held redirect is not lost.
    always_comb begin
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (write_en_i) begin
            if (flush_i) begin
                instr_d    = NOP_WORD;
                pc_plus4_d = 32'h0000_0000;
                valid_d    = 1'b0;
            end else begin
                instr_d    = instr_i;
                pc_plus4_d = pc_plus4_i;
                valid_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q    <= NOP_WORD;
            pc_plus4_q <= 32'h0000_0000;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_o    = instr_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection (seq/jump/branch/jr),
// and the IF/ID register with stall and flush.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC,
    parameter logic [31:0] NOP_WORD = cpu_defs::NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCWrite,
    input  logic        IFIDWrite,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] PC_out,
    output logic [31:0] IF_ID_instruction,
    output logic [31:0] IF_ID_PC_plus4,
    output logic        IF_ID_valid,
    output logic [31:0] fetch_count
);

    import cpu_defs::*;

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   count_q, count_d;
    logic [31:0]   pc_plus4;
    logic [31:0]   target_raw;
    logic [31:0]   next_pc;
    redirect_sel_e sel;
    logic          redirect;
    logic          flush;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        sel        = redirect_select(jr, branch_taken, jump);
        redirect   = (sel != SEL_SEQ);
        target_raw = pc_plus4;
        case (sel)
            SEL_JR:     target_raw = jr_target;
            SEL_BRANCH: target_raw = branch_target;
            SEL_JUMP:   target_raw = jump_target;
            default:    target_raw = pc_plus4;
        endcase
        next_pc = redirect ? (target_raw & ~32'h3) : pc_plus4;
    end

    // A redirect only takes effect (and flushes) on a cycle the PC may advance.
    assign flush   = redirect & PCWrite;
    assign pc_d    = PCWrite ? next_pc : pc_q;
    assign count_d = (IFIDWrite && !flush) ? count_q + 32'd1 : count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            count_q <= 32'h0000_0000;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    if_id_reg #(
        .NOP_WORD (NOP_WORD)
    ) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .write_en_i (IFIDWrite),
        .flush_i    (flush),
        .instr_i    (imem_data),
        .pc_plus4_i (pc_plus4),
        .instr_o    (IF_ID_instruction),
        .pc_plus4_o (IF_ID_PC_plus4),
        .valid_o    (IF_ID_valid)
    );

    assign PC_out      = pc_q;
    assign imem_addr   = pc_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a spec-level model checked every cycle,
// plus hand-computed expectations at key points of the stimulus.
module tb_fetch_stage;

    localparam logic [31:0] IMEM_BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCWrite, IFIDWrite;
    logic        branch_taken, jump, jr;
    logic [31:0] branch_target, jump_target, jr_target;
    logic [31:0] imem_addr, imem_data;
    logic [31:0] PC_out, IF_ID_instruction, IF_ID_PC_plus4, fetch_count;
    logic        IF_ID_valid;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit model_on  = 1'b0;

    // Instruction memory: word at byte address A is A + IMEM_BASE.
    assign imem_data = imem_addr + IMEM_BASE;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk               (clk),
        .rst               (rst),
        .PCWrite           (PCWrite),
        .IFIDWrite         (IFIDWrite),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .jump              (jump),
        .jump_target       (jump_target),
        .jr                (jr),
        .jr_target         (jr_target),
        .imem_addr         (imem_addr),
        .imem_data         (imem_data),
        .PC_out            (PC_out),
        .IF_ID_instruction (IF_ID_instruction),
        .IF_ID_PC_plus4    (IF_ID_PC_plus4),
        .IF_ID_valid       (IF_ID_valid),
        .fetch_count       (fetch_count)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    endtask

    // Behavioural model: what a fetch stage must do on each edge.
    logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
    logic        m_valid;

    always @(posedge clk) begin
        logic [31:0] fetched, target;
        logic        taken;
        if (rst) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
        end else if (PCWrite && IFIDWrite) begin
            fetched = m_pc + IMEM_BASE;
            taken   = jr || branch_taken || jump;
            target  = jr ? jr_target : (branch_taken ? branch_target : jump_target);
            if (taken) begin
                m_pc = {target[31:2], 2'b00};
                m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            end else begin
                m_instr = fetched; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
                m_pc = m_pc + 32'd4;
                m_cnt = m_cnt + 32'd1;
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("cyc_pc",    PC_out,            m_pc);
            chk("cyc_imem",  imem_addr,         m_pc);
            chk("cyc_instr", IF_ID_instruction, m_instr);
            chk("cyc_pc4",   IF_ID_PC_plus4,    m_pc4);
            chk("cyc_valid", {31'b0, IF_ID_valid}, {31'b0, m_valid});
            chk("cyc_count", fetch_count,       m_cnt);
            $display("cycle t=%0t pc=%h instr=%h pc4=%h valid=%0b count=%0d",
                     $time, PC_out, IF_ID_instruction, IF_ID_PC_plus4, IF_ID_valid, fetch_count);
        end
    end

    task automatic clear_ctrl();
        branch_taken = 0; jump = 0; jr = 0;
        branch_target = 0; jump_target = 0; jr_target = 0;
        PCWrite = 1; IFIDWrite = 1;
    endtask

    task automatic tick(); @(negedge clk); endtask

    task automatic expect_state(input string nm, input logic [31:0] pc, input logic [31:0] ins,
                                input logic [31:0] pc4, input logic v, input logic [31:0] cnt);
        chk({nm, "_pc"},    PC_out, pc);
        chk({nm, "_instr"}, IF_ID_instruction, ins);
        chk({nm, "_pc4"},   IF_ID_PC_plus4, pc4);
        chk({nm, "_valid"}, {31'b0, IF_ID_valid}, {31'b0, v});
        chk({nm, "_count"}, fetch_count, cnt);
    endtask

    initial begin
        rst = 1;
        clear_ctrl();
        tick(); tick();
        model_on = 1'b1;
        expect_state("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        rst = 0;

        // Free run
        tick(); expect_state("run1", 32'h4, 32'h1000_0000, 32'h4, 1'b1, 32'd1);
        tick(); expect_state("run2", 32'h8, 32'h1000_0004, 32'h8, 1'b1, 32'd2);

        // Two-cycle stall at PC=8
        PCWrite = 0; IFIDWrite = 0;
        tick(); tick(); expect_state("stall", 32'h8, 32'h1000_0004, 32'h8, 1'b1, 32'd2);
        PCWrite = 1; IFIDWrite = 1;
        tick(); expect_state("resume", 32'hC, 32'h1000_0008, 32'hC, 1'b1, 32'd3);
        tick(); chk("at10_pc", PC_out, 32'h10);

        // Taken branch at PC=10
        branch_taken = 1; branch_target = 32'h40;
        tick(); expect_state("br_bubble", 32'h40, 32'h0, 32'h0, 1'b0, 32'd4);
        clear_ctrl();
        tick(); expect_state("br_target", 32'h44, 32'h1000_0040, 32'h44, 1'b1, 32'd5);

        // jr and jump together: jr wins, low bits cleared
        jr = 1; jr_target = 32'h83; jump = 1; jump_target = 32'h200;
        tick(); expect_state("jr_prio", 32'h80, 32'h0, 32'h0, 1'b0, 32'd5);
        clear_ctrl();
        tick(); expect_state("jr_after", 32'h84, 32'h1000_0080, 32'h84, 1'b1, 32'd6);

        // Branch during stall is ignored, then honoured when re-asserted
        branch_taken = 1; branch_target = 32'h300; PCWrite = 0; IFIDWrite = 0;
        tick(); expect_state("br_stall", 32'h84, 32'h1000_0080, 32'h84, 1'b1, 32'd6);
        PCWrite = 1; IFIDWrite = 1;
        tick(); expect_state("br_release", 32'h300, 32'h0, 32'h0, 1'b0, 32'd6);
        clear_ctrl();
        tick(); chk("br_rel_next_pc", PC_out, 32'h304);

        // PC wrap at the top of the address space
        jr = 1; jr_target = 32'hFFFF_FFFC;
        tick(); chk("wrap_setup_pc", PC_out, 32'hFFFF_FFFC);
        clear_ctrl();
        tick(); expect_state("wrap", 32'h0, 32'h0FFF_FFFC, 32'h0, 1'b1, 32'd8);
        tick(); expect_state("wrap_next", 32'h4, 32'h1000_0000, 32'h4, 1'b1, 32'd9);

        // Mid-run reset overrides a simultaneous redirect
        rst = 1; jr = 1; jr_target = 32'h500;
        tick(); expect_state("mid_reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        rst = 0; clear_ctrl();
        tick(); expect_state("post_reset", 32'h4, 32'h1000_0000, 32'h4, 1'b1, 32'd1);
        tick();

        model_on = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
